sdram_to_hps_xfer_ctrl: RTL and testbench
=========================================

// Module: sdram_to_hps_xfer_ctrl
// PURPOSE
//  Sequences 16-bit SDRAM-side data words to the HPS over an Avalon-MM slave
//  with 4 word addresses. Buffers words from a valid/ready sink in a small FIFO.
//  Counts a programmed burst, raises a done interrupt once the HPS has drained it,
//  and replaces a bare input PIO so that no words are lost between HPS polls.
// PARAMETERS
//  DATA_W      16  width of sink data and of FIFO entries (<=16)
//  FIFO_DEPTH  8   FIFO entries; power of two, 2..128
//  CNT_W       16  width of burst-length and remaining counters
// PORTS
//  clk         in   1       system clock
//  reset_n     in   1       asynchronous active-low reset
//  address     in   2       Avalon word address
//  read        in   1       Avalon read strobe
//  write       in   1       Avalon write strobe
//  writedata   in   32      Avalon write data
//  readdata    out  32      Avalon read data, registered
//  snk_data    in   DATA_W  SDRAM-side data word
//  snk_valid   in   1       snk_data valid
//  snk_ready   out  1       block accepts word (transfer = valid & ready)
//  irq         out  1       level interrupt, high in DONE
// BEHAVIOUR
//  Clock/reset: single clock; reset is asynchronous and active-low on reset_n.
//   Reset values: readdata=0, snk_ready=0, irq=0, FIFO empty, state IDLE,
//   BURST_LEN=0, remaining=0, underflow=0.
//  Register map (readdata registered: valid the cycle after read; zero-extended):
//   0 DATA    R: FIFO head in [DATA_W-1:0]; read pops when non-empty;
//             empty read returns 0, sets sticky underflow, no pop.
//   1 STATUS  R: [0]empty [1]full [2]underflow [3]irq [5:4]state
//             [15:8]fifo count [31:16]remaining words.
//   2 CONTROL W: [0]start [1]flush [2]clear underflow/irq; R: 0.
//   3 BURST   R/W: [CNT_W-1:0] burst length; write ignored unless state IDLE.
//  FSM states (encoding): IDLE=0, RUN=1, DRAIN=2, DONE=3.
//   IDLE : snk_ready=0. Start -> RUN, remaining<=BURST. Start with BURST=0 ->
//          RUN in continuous mode (no count, never leaves RUN by count).
//   RUN  : snk_ready = !full. Each transfer pushes and decrements remaining.
//          Last word accepted (remaining 1->0) -> DRAIN the next cycle.
//   DRAIN: snk_ready=0. FIFO empty (after pops) -> DONE.
//   DONE : irq=1. Clear (CONTROL[2]) -> IDLE. Start -> RUN (new burst).
//  Flush (CONTROL[1]) in any state: FIFO emptied, remaining=0, ->IDLE, irq=0.
//   Flush with start in the same write: flush wins.
//  FIFO: simultaneous push and pop leaves count unchanged, head advances.
//   A push into an empty FIFO is readable on the next DATA read, not the same cycle.
//   Pointers wrap modulo FIFO_DEPTH; count is CLOG2(FIFO_DEPTH)+1 bits wide.
//  Read and write in the same cycle: both take effect; read sees pre-write state.
//  Writes to DATA and reads of CONTROL have no side effects.
//  Mid-operation reset: all state returns to reset values immediately.
// STRUCTURE
//  Package sdram_xfer_pkg: state enum, register address constants, STATUS bit
//   positions, CONTROL bit positions.
//  Sub-module xfer_sync_fifo (DATA_W, FIFO_DEPTH): push/pop/flush, head,
//   count, full, empty. The FSM, counters and Avalon decode are in the top module.
// TESTING
//  1 BURST=4, start, 4 words 0x1111..0x4444 -> STATUS state=DRAIN, count=4;
//    4 DATA reads return 0x1111..0x4444 in order -> state=DONE, irq=1.
//  2 BURST=12, FIFO_DEPTH=8, no reads -> snk_ready=0 after 8 words, full=1;
//    one read -> one more word accepted, remaining=3.
//  3 DATA read when empty -> readdata=0, underflow=1; CONTROL=0x4 -> underflow=0.
//  4 Push and pop in the same cycle at count=3 -> count stays 3, order kept.
//  5 Flush mid-RUN with count=5 -> empty=1, state=IDLE, remaining=0, irq=0.
//  6 BURST=0, start, 20 words with interleaved reads -> stays RUN, no irq;
//    reset_n pulsed mid-stream -> all registers at reset values.

Source files
------------

// File: rtl/sdram_xfer_pkg.sv
// Shared types and register-map constants for the SDRAM-to-HPS transfer controller.
package sdram_xfer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } xfer_state_e;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_BURST   = 2'd3;

  localparam int STAT_EMPTY      = 0;
  localparam int STAT_FULL       = 1;
  localparam int STAT_UNDERFLOW  = 2;
  localparam int STAT_IRQ        = 3;
  localparam int STAT_STATE_LSB  = 4;
  localparam int STAT_COUNT_LSB  = 8;
  localparam int STAT_REMAIN_LSB = 16;

  localparam int CTRL_START = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_CLEAR = 2;

endpackage

// File: rtl/xfer_sync_fifo.sv
// Single-clock FIFO with synchronous flush; head is the oldest entry, valid when not empty.
module xfer_sync_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [DATA_W-1:0]            head,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sdram_to_hps_xfer_ctrl.sv
// Buffers SDRAM-side words for the HPS, counts a programmed burst and raises irq once drained.
module sdram_to_hps_xfer_ctrl
  import sdram_xfer_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  output logic              irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  xfer_state_e       state_q, state_d;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              cont_q, cont_d;
  logic              underflow_q, underflow_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              snk_ready_q, snk_ready_d;
  logic              irq_q, irq_d;

  logic [DATA_W-1:0] fifo_head;
  logic [CW-1:0]     fifo_count, fifo_count_nxt;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic              rd_data, wr_ctrl, wr_burst;
  logic              do_start, do_flush, do_clear;
  logic [31:0]       status_word;
  logic              unused_wdata;

  assign unused_wdata = ^writedata[31:CNT_W];

  assign rd_data  = read  && (address == ADDR_DATA);
  assign wr_ctrl  = write && (address == ADDR_CONTROL);
  assign wr_burst = write && (address == ADDR_BURST);
  assign do_start = wr_ctrl && writedata[CTRL_START];
  assign do_flush = wr_ctrl && writedata[CTRL_FLUSH];
  assign do_clear = wr_ctrl && writedata[CTRL_CLEAR];

  // snk_ready is registered, so it already guarantees the FIFO has room.
  assign push = snk_valid && snk_ready_q;
  assign pop  = rd_data && !fifo_empty;
  assign fifo_count_nxt = do_flush ? '0 : (fifo_count + CW'(push) - CW'(pop));

  xfer_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (snk_data),
    .pop       (pop),
    .flush     (do_flush),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    status_word = '0;
    status_word[STAT_EMPTY]     = fifo_empty;
    status_word[STAT_FULL]      = fifo_full;
    status_word[STAT_UNDERFLOW] = underflow_q;
    status_word[STAT_IRQ]       = irq_q;
    status_word[STAT_STATE_LSB +: 2]  = state_q;
    status_word[STAT_COUNT_LSB +: 8]  = 8'(fifo_count);
    status_word[STAT_REMAIN_LSB +: 16] = 16'(remaining_q);
  end

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    remaining_d = remaining_q;
    cont_d      = cont_q;
    underflow_d = underflow_q;
    readdata_d  = '0;

    if (wr_burst && state_q == ST_IDLE) burst_d = writedata[CNT_W-1:0];
    if (do_clear) underflow_d = 1'b0;
    if (rd_data && fifo_empty) underflow_d = 1'b1;

    if (read) begin
      case (address)
        ADDR_DATA:   readdata_d = fifo_empty ? '0 : 32'(fifo_head);
        ADDR_STATUS: readdata_d = status_word;
        ADDR_BURST:  readdata_d = 32'(burst_q);
        default:     readdata_d = '0;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (do_start) begin
          state_d     = ST_RUN;
          remaining_d = burst_q;
          cont_d      = (burst_q == '0);
        end
      end
      ST_RUN: begin
        if (push && !cont_q) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_count_nxt == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (do_start) begin
          state_d     = ST_RUN;
          remaining_d = burst_q;
          cont_d      = (burst_q == '0);
        end else if (do_clear) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides anything else requested in the same write.
    if (do_flush) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      cont_d      = 1'b0;
    end

    snk_ready_d = (state_d == ST_RUN) && (fifo_count_nxt != CW'(FIFO_DEPTH));
    irq_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      burst_q     <= '0;
      remaining_q <= '0;
      cont_q      <= 1'b0;
      underflow_q <= 1'b0;
      readdata_q  <= '0;
      snk_ready_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      remaining_q <= remaining_d;
      cont_q      <= cont_d;
      underflow_q <= underflow_d;
      readdata_q  <= readdata_d;
      snk_ready_q <= snk_ready_d;
      irq_q       <= irq_d;
    end
  end

  assign readdata  = readdata_q;
  assign snk_ready = snk_ready_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_sdram_to_hps_xfer_ctrl.sv
// Directed vector table plus hand-written sequences for the transfer controller.
module tb_sdram_to_hps_xfer_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] snk_data;
  logic        snk_valid;
  logic        snk_ready;
  logic        irq;

  int total;
  int bad;

  typedef struct {
    string       name;
    logic [1:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        sv;
    logic [15:0] sd;
    logic [31:0] expRd;
    logic        expReady;
    logic        expIrq;
  } vec_t;

  vec_t vecs[20];

  sdram_to_hps_xfer_ctrl #(
    .DATA_W     (16),
    .FIFO_DEPTH (8),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .snk_data  (snk_data),
    .snk_valid (snk_valid),
    .snk_ready (snk_ready),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, returns 1ns after the rising edge.
  task automatic applyStimulus(input logic [1:0] a, input logic r, input logic w,
                               input logic [31:0] wd, input logic v, input logic [15:0] d);
    @(negedge clk);
    address   = a;
    read      = r;
    write     = w;
    writedata = wd;
    snk_valid = v;
    snk_data  = d;
    @(posedge clk);
    #1;
    read      = 1'b0;
    write     = 1'b0;
    snk_valid = 1'b0;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] wd);
    applyStimulus(a, 1'b0, 1'b1, wd, 1'b0, 16'h0);
  endtask

  task automatic busReadCheck(input string name, input logic [1:0] a, input logic [31:0] expected);
    applyStimulus(a, 1'b1, 1'b0, 32'h0, 1'b0, 16'h0);
    checkOutput(name, readdata, expected);
  endtask

  task automatic pushWord(input logic [15:0] d);
    applyStimulus(2'd1, 1'b0, 1'b0, 32'h0, 1'b1, d);
  endtask

  initial begin
    logic [15:0] w;
    logic        acc;
    logic        doRead;
    logic [31:0] expHead;
    logic [15:0] model[$];
    int          accepted;

    total = 0;
    bad = 0;
    address = 2'd0; read = 1'b0; write = 1'b0; writedata = '0;
    snk_valid = 1'b0; snk_data = '0;
    reset_n = 1'b0;

    // name, addr, rd, wr, wdata, sv, sd, expRd, expReady, expIrq
    vecs[0]  = '{"burst4_wr",   2'd3, 1'b0, 1'b1, 32'd4,  1'b0, 16'h0000, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{"start",       2'd2, 1'b0, 1'b1, 32'h1,  1'b0, 16'h0000, 32'h0, 1'b1, 1'b0};
    vecs[2]  = '{"push1",       2'd1, 1'b0, 1'b0, 32'h0,  1'b1, 16'h1111, 32'h0, 1'b1, 1'b0};
    vecs[3]  = '{"push2",       2'd1, 1'b0, 1'b0, 32'h0,  1'b1, 16'h2222, 32'h0, 1'b1, 1'b0};
    vecs[4]  = '{"push3",       2'd1, 1'b0, 1'b0, 32'h0,  1'b1, 16'h3333, 32'h0, 1'b1, 1'b0};
    vecs[5]  = '{"push4_last",  2'd1, 1'b0, 1'b0, 32'h0,  1'b1, 16'h4444, 32'h0, 1'b0, 1'b0};
    vecs[6]  = '{"stat_drain",  2'd1, 1'b1, 1'b0, 32'h0,  1'b0, 16'h0000, 32'h0000_0420, 1'b0, 1'b0};
    vecs[7]  = '{"data1",       2'd0, 1'b1, 1'b0, 32'h0,  1'b0, 16'h0000, 32'h0000_1111, 1'b0, 1'b0};
    vecs[8]  = '{"data2",       2'd0, 1'b1, 1'b0, 32'h0,  1'b0, 16'h0000, 32'h0000_2222, 1'b0, 1'b0};
    vecs[9]  = '{"data3",       2'd0, 1'b1, 1'b0, 32'h0,  1'b0, 16'h0000, 32'h0000_3333, 1'b0, 1'b0};
    vecs[10] = '{"data4_done",  2'd0, 1'b1, 1'b0, 32'h0,  1'b0, 16'h0000, 32'h0000_4444, 1'b0, 1'b1};
    vecs[11] = '{"stat_done",   2'd1, 1'b1, 1'b0, 32'h0,  1'b0, 16'h0000, 32'h0000_0039, 1'b0, 1'b1};
    vecs[12] = '{"clear_done",  2'd2, 1'b0, 1'b1, 32'h4,  1'b0, 16'h0000, 32'h0, 1'b0, 1'b0};
    vecs[13] = '{"stat_idle",   2'd1, 1'b1, 1'b0, 32'h0,  1'b0, 16'h0000, 32'h0000_0001, 1'b0, 1'b0};
    vecs[14] = '{"data_empty",  2'd0, 1'b1, 1'b0, 32'h0,  1'b0, 16'h0000, 32'h0, 1'b0, 1'b0};
    vecs[15] = '{"stat_uflow",  2'd1, 1'b1, 1'b0, 32'h0,  1'b0, 16'h0000, 32'h0000_0005, 1'b0, 1'b0};
    vecs[16] = '{"clear_uflow", 2'd2, 1'b0, 1'b1, 32'h4,  1'b0, 16'h0000, 32'h0, 1'b0, 1'b0};
    vecs[17] = '{"stat_noufl",  2'd1, 1'b1, 1'b0, 32'h0,  1'b0, 16'h0000, 32'h0000_0001, 1'b0, 1'b0};
    vecs[18] = '{"burst_rd",    2'd3, 1'b1, 1'b0, 32'h0,  1'b0, 16'h0000, 32'h0000_0004, 1'b0, 1'b0};
    vecs[19] = '{"ctrl_rd",     2'd2, 1'b1, 1'b0, 32'h0,  1'b0, 16'h0000, 32'h0, 1'b0, 1'b0};

    #12;
    checkOutput("rst_readdata", readdata, 32'h0);
    checkOutput("rst_ready", {31'h0, snk_ready}, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    busReadCheck("rst_status", 2'd1, 32'h0000_0001);

    // Basic burst of four, drain, done/clear, and the underflow path.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, vecs[i].sv, vecs[i].sd);
      if (vecs[i].rd) checkOutput({vecs[i].name, "_rd"}, readdata, vecs[i].expRd);
      checkOutput({vecs[i].name, "_ready"}, {31'h0, snk_ready}, {31'h0, vecs[i].expReady});
      checkOutput({vecs[i].name, "_irq"}, {31'h0, irq}, {31'h0, vecs[i].expIrq});
    end

    // Backpressure: burst of 12 into an 8-deep FIFO with no reads.
    busWrite(2'd3, 32'd12);
    busWrite(2'd2, 32'h1);
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      w = 16'hA000 + 16'(accepted);
      acc = snk_ready;
      pushWord(w);
      if (acc) accepted++;
    end
    checkOutput("bp_accepted", 32'(accepted), 32'd8);
    checkOutput("bp_ready_low", {31'h0, snk_ready}, 32'h0);
    busReadCheck("bp_status_full", 2'd1, 32'h0004_0812);
    busReadCheck("bp_pop_head", 2'd0, 32'h0000_A000);
    checkOutput("bp_ready_again", {31'h0, snk_ready}, 32'h1);
    pushWord(16'hA008);
    busReadCheck("bp_status_rem3", 2'd1, 32'h0003_0812);
    busWrite(2'd2, 32'h2);
    busReadCheck("bp_flushed", 2'd1, 32'h0000_0001);

    // Simultaneous push and pop at count 3.
    busWrite(2'd3, 32'd10);
    busWrite(2'd2, 32'h1);
    pushWord(16'hB001);
    pushWord(16'hB002);
    pushWord(16'hB003);
    applyStimulus(2'd0, 1'b1, 1'b0, 32'h0, 1'b1, 16'hB004);
    checkOutput("pp_head", readdata, 32'h0000_B001);
    busReadCheck("pp_status", 2'd1, 32'h0006_0310);
    busReadCheck("pp_rd2", 2'd0, 32'h0000_B002);
    busReadCheck("pp_rd3", 2'd0, 32'h0000_B003);
    busReadCheck("pp_rd4", 2'd0, 32'h0000_B004);
    busWrite(2'd2, 32'h2);

    // Flush mid-run with five words queued; start in the same write must lose.
    busWrite(2'd2, 32'h1);
    for (int i = 0; i < 5; i++) pushWord(16'hD000 + 16'(i));
    busReadCheck("fl_status_pre", 2'd1, 32'h0005_0510);
    busWrite(2'd2, 32'h3);
    busReadCheck("fl_status_post", 2'd1, 32'h0000_0001);
    checkOutput("fl_irq", {31'h0, irq}, 32'h0);
    checkOutput("fl_ready", {31'h0, snk_ready}, 32'h0);

    // Continuous mode with a push and a pop every cycle, checked against a queue model.
    busWrite(2'd3, 32'd0);
    busWrite(2'd2, 32'h1);
    for (int i = 0; i < 20; i++) begin
      acc = snk_ready;
      doRead = (i > 0);
      expHead = (model.size() > 0) ? 32'(model[0]) : 32'h0;
      applyStimulus(2'd0, doRead, 1'b0, 32'h0, 1'b1, 16'hC000 + 16'(i));
      if (doRead) begin
        checkOutput("cm_data", readdata, expHead);
        if (model.size() > 0) void'(model.pop_front());
      end
      if (acc) model.push_back(16'hC000 + 16'(i));
      else checkOutput("cm_ready", {31'h0, acc}, 32'h1);
    end
    checkOutput("cm_irq", {31'h0, irq}, 32'h0);
    busReadCheck("cm_status", 2'd1, 32'h0000_0110);

    // Asynchronous reset in the middle of a stream.
    @(negedge clk);
    snk_valid = 1'b1;
    snk_data = 16'hEEEE;
    read = 1'b1;
    address = 2'd1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("ar_readdata", readdata, 32'h0);
    checkOutput("ar_ready", {31'h0, snk_ready}, 32'h0);
    checkOutput("ar_irq", {31'h0, irq}, 32'h0);
    read = 1'b0;
    snk_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    busReadCheck("ar_status", 2'd1, 32'h0000_0001);
    busReadCheck("ar_burst", 2'd3, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
